// File: rtl/store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow_unit
// Brief    : SW/SH/SB store narrowing into a word-wide memory without byte
//            enables; sub-word stores use read-modify-write. Optional macro
//            STORE_ALIGN_CHECK_EN rejects misaligned half/word stores.
// Revision : 1.0
// ============================================================================
module store_narrow_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_wr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_wready
);

    localparam logic [1:0] c_op_word = 2'b00;
    localparam logic [1:0] c_op_half = 2'b01;
    localparam logic [1:0] c_op_byte = 2'b10;
    localparam logic [1:0] c_op_rsvd = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_op;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata_lo;
    logic        r_err;
    logic        w_misaligned;
    logic        w_reject;
    logic        w_accept;
    logic [31:0] w_merged;

`ifdef STORE_ALIGN_CHECK_EN
    assign w_misaligned = ((op == c_op_half) && addr[0]) ||
                          ((op == c_op_word) && (addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_reject = (op == c_op_rsvd) || w_misaligned;
    assign w_accept = (r_state == S_IDLE) && start;

    // Replace only the addressed lane of the word read back from memory.
    always_comb begin
        w_merged = mem_rdata;
        if (r_op == c_op_half) begin
            if (r_lane[1]) begin
                w_merged[31:16] = r_wdata_lo;
            end else begin
                w_merged[15:0] = r_wdata_lo;
            end
        end else if (r_op == c_op_byte) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata_lo[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_reject) begin
                        w_state_next = S_FIN;
                    end else if (op == c_op_word) begin
                        w_state_next = S_WR;
                    end else begin
                        w_state_next = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                busy         = 1'b1;
                mem_rd       = 1'b1;
                w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    w_state_next = S_WR;
                end
            end
            S_WR: begin
                busy   = 1'b1;
                mem_wr = 1'b1;
                if (mem_wready) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                busy         = 1'b1;
                done         = 1'b1;
                err          = r_err;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Word stores write the full register value; sub-word stores overwrite
    // mem_wdata with the merged word when the read returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= 2'b00;
            r_lane     <= 2'b00;
            r_wdata_lo <= 16'h0;
            r_err      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_op       <= op;
                r_lane     <= addr[1:0];
                r_wdata_lo <= wdata[15:0];
                r_err      <= w_reject;
                mem_addr   <= {addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata  <= wdata;
            end else if ((r_state == S_RD_WAIT) && mem_rvalid) begin
                mem_wdata <= w_merged;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_narrow_unit
// Brief    : Directed self-checking bench for store_narrow_unit.
// Revision : 1.0
// ============================================================================
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rvalid = 1'b0;
    logic        mem_wready = 1'b0;
    logic        busy, done, err, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    int          obs_done_cyc, obs_done_cnt, obs_err_cnt, obs_rd_cnt, obs_wr_cnt;
    int          obs_busy_cnt, obs_unstable;
    logic [31:0] obs_rd_addr, obs_wr_addr, obs_wr_data;

    store_narrow_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_wready(mem_wready)
    );

    always #5 clk = ~clk;

    // Issues one request at cycle 0 (start held for 'hold' cycles) and plays a
    // memory that answers a read rdel cycles late and accepts a write wdel
    // cycles after mem_wr first rises. Records what it saw over 16 cycles.
    task automatic do_store(input logic [1:0] t_op, input logic [31:0] t_addr,
                            input logic [31:0] t_wdata, input logic [31:0] t_mem,
                            input int rdel, input int wdel, input int hold);
        int          rd_cyc;
        int          wr_first;
        logic [31:0] prev_wd;
        rd_cyc = -1; wr_first = -1; prev_wd = 32'h0;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_err_cnt = 0; obs_rd_cnt = 0;
        obs_wr_cnt = 0; obs_busy_cnt = 0; obs_unstable = 0;
        obs_rd_addr = 32'h0; obs_wr_addr = 32'h0; obs_wr_data = 32'h0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            start = (cyc < hold); op = t_op; addr = t_addr; wdata = t_wdata;
            if (busy) obs_busy_cnt++;
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = cyc;
            end
            if (err) obs_err_cnt++;
            if (mem_rd) begin
                obs_rd_cnt++; rd_cyc = cyc; obs_rd_addr = mem_addr;
            end
            mem_rvalid = (rd_cyc >= 0) && (cyc == rd_cyc + 1 + rdel);
            mem_rdata  = mem_rvalid ? t_mem : 32'h0BAD_F00D;
            if (mem_wr) begin
                if (wr_first < 0) begin
                    wr_first = cyc; prev_wd = mem_wdata;
                end else if (mem_wdata !== prev_wd) begin
                    obs_unstable++;
                end
                mem_wready = (cyc >= wr_first + wdel);
                if (mem_wready) begin
                    obs_wr_cnt++; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata;
                end
            end else begin
                mem_wready = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata} !== 69'h0) begin errors++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b addr=%h wdata=%h want all 0", busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        do_store(2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 1);
        checks++; if (obs_done_cyc !== 2) begin errors++; $display("FAIL sw_done_cycle: got %0d want 2", obs_done_cyc); end
        checks++; if (obs_rd_cnt !== 0) begin errors++; $display("FAIL sw_no_read: got %0d reads want 0", obs_rd_cnt); end
        checks++; if (obs_wr_addr !== 32'h10) begin errors++; $display("FAIL sw_addr: got %h want 00000010", obs_wr_addr); end
        checks++; if (obs_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data: got %h want deadbeef", obs_wr_data); end
        checks++; if (obs_busy_cnt !== 2) begin errors++; $display("FAIL sw_busy_cycles: got %0d want 2", obs_busy_cnt); end
        checks++; if (obs_err_cnt !== 0) begin errors++; $display("FAIL sw_err: got %0d want 0", obs_err_cnt); end
        // Misaligned word with write accept delayed one cycle
        do_store(2'b00, 32'h46, 32'h01020304, 32'h0, 0, 1, 1);
`ifdef STORE_ALIGN_CHECK_EN
        checks++; if (obs_done_cyc !== 1 || obs_err_cnt !== 1 || obs_wr_cnt !== 0) begin errors++; $display("FAIL sw_misaligned: got done=%0d err=%0d wr=%0d want 1 1 0", obs_done_cyc, obs_err_cnt, obs_wr_cnt); end
`else
        checks++; if (obs_done_cyc !== 3 || obs_wr_addr !== 32'h44 || obs_wr_data !== 32'h01020304) begin errors++; $display("FAIL sw_wait: got done=%0d addr=%h data=%h want 3 00000044 01020304", obs_done_cyc, obs_wr_addr, obs_wr_data); end
`endif
    endtask

    task automatic test_byte();
        do_store(2'b10, 32'h22, 32'h123456AB, 32'h11223344, 0, 0, 1);
        checks++; if (obs_rd_cnt !== 1 || obs_rd_addr !== 32'h20) begin errors++; $display("FAIL sb_read: got cnt=%0d addr=%h want 1 00000020", obs_rd_cnt, obs_rd_addr); end
        checks++; if (obs_wr_data !== 32'h11AB3344) begin errors++; $display("FAIL sb_lane2_data: got %h want 11ab3344", obs_wr_data); end
        checks++; if (obs_done_cyc !== 4 || obs_err_cnt !== 0) begin errors++; $display("FAIL sb_done: got cyc=%0d err=%0d want 4 0", obs_done_cyc, obs_err_cnt); end
        do_store(2'b10, 32'h23, 32'hFFFFFF5A, 32'hA5A5A5A5, 0, 0, 1);
        checks++; if (obs_wr_data !== 32'h5AA5A5A5) begin errors++; $display("FAIL sb_lane3_data: got %h want 5aa5a5a5", obs_wr_data); end
        do_store(2'b10, 32'h20, 32'h000000C3, 32'hFFFFFFFF, 1, 0, 1);
        checks++; if (obs_wr_data !== 32'hFFFFFFC3 || obs_done_cyc !== 5) begin errors++; $display("FAIL sb_lane0: got data=%h done=%0d want ffffffc3 5", obs_wr_data, obs_done_cyc); end
    endtask

    task automatic test_half();
        do_store(2'b01, 32'h32, 32'hFFFFCAFE, 32'h00000000, 3, 2, 1);
        checks++; if (obs_wr_data !== 32'hCAFE0000) begin errors++; $display("FAIL sh_upper_data: got %h want cafe0000", obs_wr_data); end
        checks++; if (obs_done_cyc !== 9) begin errors++; $display("FAIL sh_wait_done: got %0d want 9", obs_done_cyc); end
        checks++; if (obs_unstable !== 0 || obs_wr_cnt !== 1) begin errors++; $display("FAIL sh_wr_hold: got unstable=%0d writes=%0d want 0 1", obs_unstable, obs_wr_cnt); end
        checks++; if (obs_busy_cnt !== 9) begin errors++; $display("FAIL sh_busy_cycles: got %0d want 9", obs_busy_cnt); end
        do_store(2'b01, 32'h30, 32'h12349876, 32'hFFFFFFFF, 0, 0, 1);
        checks++; if (obs_wr_data !== 32'hFFFF9876) begin errors++; $display("FAIL sh_lower_data: got %h want ffff9876", obs_wr_data); end
    endtask

    task automatic test_align();
        do_store(2'b01, 32'h31, 32'h0000BEEF, 32'h00000000, 0, 0, 1);
`ifdef STORE_ALIGN_CHECK_EN
        checks++; if (obs_done_cyc !== 1 || obs_err_cnt !== 1) begin errors++; $display("FAIL sh_misaligned_err: got done=%0d err=%0d want 1 1", obs_done_cyc, obs_err_cnt); end
        checks++; if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0) begin errors++; $display("FAIL sh_misaligned_mem: got rd=%0d wr=%0d want 0 0", obs_rd_cnt, obs_wr_cnt); end
`else
        checks++; if (obs_wr_data !== 32'h0000BEEF || obs_wr_addr !== 32'h30) begin errors++; $display("FAIL sh_unaligned_data: got data=%h addr=%h want 0000beef 00000030", obs_wr_data, obs_wr_addr); end
        checks++; if (obs_done_cyc !== 4 || obs_err_cnt !== 0) begin errors++; $display("FAIL sh_unaligned_done: got done=%0d err=%0d want 4 0", obs_done_cyc, obs_err_cnt); end
`endif
    endtask

    task automatic test_reserved();
        do_store(2'b11, 32'h50, 32'h55555555, 32'h0, 0, 0, 2);
        checks++; if (obs_done_cyc !== 1 || obs_err_cnt !== 1) begin errors++; $display("FAIL rsvd_err: got done=%0d err=%0d want 1 1", obs_done_cyc, obs_err_cnt); end
        checks++; if (obs_done_cnt !== 1) begin errors++; $display("FAIL rsvd_single_done: got %0d dones want 1", obs_done_cnt); end
        checks++; if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0) begin errors++; $display("FAIL rsvd_no_mem: got rd=%0d wr=%0d want 0 0", obs_rd_cnt, obs_wr_cnt); end
    endtask

    task automatic test_back_to_back();
        // start held across the whole sub-word transaction: only one store
        do_store(2'b10, 32'h61, 32'h000000EE, 32'h00000000, 0, 0, 4);
        checks++; if (obs_done_cnt !== 1 || obs_wr_cnt !== 1) begin errors++; $display("FAIL busy_start_ignored: got dones=%0d writes=%0d want 1 1", obs_done_cnt, obs_wr_cnt); end
        checks++; if (obs_wr_data !== 32'h0000EE00) begin errors++; $display("FAIL busy_start_data: got %h want 0000ee00", obs_wr_data); end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; addr = 32'h24; wdata = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rstmid_read: got mem_rd=%b want 1", mem_rd); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
        checks++; if ({busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata} !== 69'h0) begin errors++; $display("FAIL rstmid_outputs: got busy=%b done=%b wr=%b addr=%h wdata=%h want all 0", busy, done, mem_wr, mem_addr, mem_wdata); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            if (mem_wr || done || busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
        do_store(2'b00, 32'h44, 32'hA5A50F0F, 32'h0, 0, 0, 1);
        checks++; if (obs_done_cyc !== 2 || obs_wr_data !== 32'hA5A50F0F) begin errors++; $display("FAIL rstmid_recover: got done=%0d data=%h want 2 a5a50f0f", obs_done_cyc, obs_wr_data); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_align();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side counterpart of the immediate/load extension path. Takes a 32-bit register value and narrows it to a word, halfword or byte store into a word-wide data memory that has no byte enables. Sub-word stores use a read-modify-write sequence. The unit sits between the multicycle controller's MEM state and the data memory port, and holds the controller in MEM via `busy` until `done`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width; memory word address is `{addr[ADDR_WIDTH-1:2], 2'b00}`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  2  store width: 00 word (SW), 01 half (SH), 10 byte (SB), 11 reserved.
- `addr`  in  ADDR_WIDTH  byte address of the store.
- `wdata`  in  32  register value; the low 8/16/32 bits are stored.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `done` when the request was rejected.
- `mem_addr`  out  ADDR_WIDTH  word-aligned memory address.
- `mem_rd`  out  1  read request, one-cycle pulse.
- `mem_rdata`  in  32  read data, valid when `mem_rvalid` is high.
- `mem_rvalid`  in  1  read data valid.
- `mem_wr`  out  1  write request, held until `mem_wready`.
- `mem_wdata`  out  32  merged write word.
- `mem_wready`  in  1  write accepted in the cycle where `mem_wr && mem_wready`.

## Operation
- Little-endian lanes:
  - byte at `addr[1:0]=n` occupies bits `8n+7:8n`.
  - half at `addr[1]=h` occupies bits `16h+15:16h`.
- On accepted `start`, the unit registers `op`, `addr` and `wdata`. Inputs are don't-care afterwards.
- States: IDLE, RD_REQ, RD_WAIT, WR, FIN.
  - IDLE: `start` with a legal request → WR if `op=00`, else → RD_REQ. An illegal request → FIN with err.
  - RD_REQ: assert `mem_rd` for exactly one cycle → RD_WAIT.
  - RD_WAIT: wait for `mem_rvalid`. Capture `mem_rdata`, then replace the target lane with the low bits of `wdata` → WR.
  - WR: assert `mem_wr` with the merged word, or the full `wdata` for word stores. Hold it until `mem_wready`, then → FIN.
  - FIN: `done=1`, and `err` if the request was rejected → IDLE.
- `op=11` is always rejected with no memory access.
- `start` while not in IDLE is ignored. It is not queued.
- `mem_addr` is held stable from RD_REQ through WR.
- `mem_wdata` is stable while `mem_wr` is high.
- Bits of `wdata` above the stored width are discarded. No sign or zero handling is applied to the stored value.

## Timing
- Reset value of every output is 0. `mem_addr` and `mem_wdata` reset to 32'h0. The state resets to IDLE.
- Reset in any state returns the unit to IDLE on the next edge. Any pending memory read or write is abandoned and no `done` is emitted.
- Word store with `mem_wready` tied high:
  - `start` at cycle 0.
  - `mem_wr` at cycle 1.
  - `done` at cycle 2.
  - Latency is 2 cycles.
- Sub-word store with zero-wait memory (`mem_rvalid` the cycle after `mem_rd`, `mem_wready` high):
  - `mem_rd` at cycle 1.
  - `mem_rvalid` at cycle 2.
  - `mem_wr` at cycle 3.
  - `done` at cycle 4.
- Each wait cycle on `mem_rvalid` or `mem_wready` adds exactly one cycle.
- `mem_rvalid` outside RD_WAIT is ignored. `mem_wready` outside WR is ignored.
- A rejected request gives `done`+`err` at cycle 1 (IDLE → FIN).
- `start` in the cycle `done` is high is ignored, because the unit is in FIN, not IDLE. The earliest next accept is the following cycle.

## Configuration
- `STORE_ALIGN_CHECK_EN`:
  - Defined: a misaligned request is rejected with no memory access. A half is misaligned when `addr[0]=1`; a word is misaligned when `addr[1:0]≠0`. Rejection gives `done`+`err` one cycle after `start`.
  - Undefined: no alignment check. A half uses `addr[1]` and ignores `addr[0]`. A word ignores `addr[1:0]`. `err` is asserted only for `op=11`.

## Test plan
- SW `addr=0x10`, `wdata=0xDEADBEEF`, `mem_wready=1` → `mem_wr` cycle 1 with `mem_addr=0x10` and `mem_wdata=0xDEADBEEF`, `done` cycle 2, no `mem_rd`.
- SB `addr=0x22`, `wdata=0x123456AB`, memory word `0x11223344` → `mem_rd` at `0x20`, then `mem_wdata=0x11AB3344`, `done=1`, `err=0`.
- SH `addr=0x32`, `wdata=0xFFFFCAFE`, memory word `0x00000000`, `mem_rvalid` delayed 3 cycles and `mem_wready` delayed 2 → `mem_wdata=0xCAFE0000`, `done` at cycle 9.
- SH `addr=0x31`, `wdata=0x0000BEEF`, memory word `0x00000000`:
  - With `STORE_ALIGN_CHECK_EN`: `done`+`err` at cycle 1, no `mem_rd` or `mem_wr`.
  - Without it: the store completes with `mem_wdata=0x0000BEEF` at `0x30`.
- `op=11` → `err` at cycle 1 in both builds. A second `start` while `busy` is ignored, with exactly one `done` observed.
- Assert `rst` during RD_WAIT, then `mem_rvalid` arrives → no `mem_wr` and no `done`, all outputs 0. A fresh SW afterwards completes normally.
